// File: rtl/bus_if_types_pkg.sv
// Shared bus transaction types plus the 2:1 arbiter's state encoding and
// timeout constants.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Ownership watchdog counter width, clamped to 8..32 bits.
  function automatic int unsigned arb_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    if (w < 8) w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/bus_rr_pick2.sv
// Two-way grant picker: gnt is the index of the winning requester. A tie goes
// to m0 when fixed is set; otherwise it goes to the master not served last.
module bus_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    if (req == 2'b10) begin
      gnt = 1'b1;
    end else if (req == 2'b11) begin
      gnt = fixed ? 1'b0 : ~last;
    end
  end

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Shares one slave bus port between core ibus (m0) and dbus (m1), granting one
// whole transaction per owner. Define ARB_TIMEOUT_EN for the ownership watchdog.
module bus_arbiter_2to1
  import bus_if_types_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_breq,
  input  logic        m0_bstart,
  input  ttype_e      m0_ttype,
  input  tsize_e      m0_tsize,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_bdone,
  output logic [31:0] m0_rdata,
  input  logic        m1_breq,
  input  logic        m1_bstart,
  input  ttype_e      m1_ttype,
  input  tsize_e      m1_tsize,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_bdone,
  output logic [31:0] m1_rdata,
  output logic        s_breq,
  output logic        s_bstart,
  output ttype_e      s_ttype,
  output tsize_e      s_tsize,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_bdone,
  input  logic [31:0] s_rdata,
  output logic        arb_timeout
);

  arb_state_e state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic       pick_gnt;
  logic       own_sel;
  logic       timeout_hit;

  bus_rr_pick2 u_pick (
    .req   ({m1_bstart, m0_bstart}),
    .last  (rr_last_q),
    .fixed (FIXED_PRIORITY != 0),
    .gnt   (pick_gnt)
  );

  assign own_sel = (state_q == OWN1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    s_breq    = 1'b0;
    s_bstart  = 1'b0;
    s_ttype   = READ;
    s_tsize   = WORD;
    s_addr    = '0;
    s_wdata   = '0;
    m0_bdone  = 1'b0;
    m1_bdone  = 1'b0;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
    case (state_q)
      IDLE: begin
        if (m0_bstart || m1_bstart) state_d = pick_gnt ? OWN1 : OWN0;
      end
      OWN0, OWN1: begin
        s_breq   = own_sel ? m1_breq   : m0_breq;
        s_bstart = own_sel ? m1_bstart : m0_bstart;
        s_ttype  = own_sel ? m1_ttype  : m0_ttype;
        s_tsize  = own_sel ? m1_tsize  : m0_tsize;
        s_addr   = own_sel ? m1_addr   : m0_addr;
        s_wdata  = own_sel ? m1_wdata  : m0_wdata;
        if (s_bdone || timeout_hit) begin
          state_d   = IDLE;
          rr_last_d = own_sel;
          if (own_sel) m1_bdone = 1'b1;
          else         m0_bdone = 1'b1;
          // A real slave completion always beats the watchdog in the same cycle.
          if (!s_bdone) begin
            s_bstart = 1'b0;
            if (own_sel) m1_rdata = ARB_TIMEOUT_RDATA;
            else         m0_rdata = ARB_TIMEOUT_RDATA;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = arb_cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          arb_timeout_q, arb_timeout_d;

  // Count is 0 on the first owned cycle because it is held clear in IDLE.
  always_comb begin
    cnt_d         = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
    arb_timeout_d = arb_timeout_q | (timeout_hit & ~s_bdone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      arb_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      arb_timeout_q <= arb_timeout_d;
    end
  end

  assign timeout_hit = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign arb_timeout = arb_timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign timeout_hit        = 1'b0;
  assign arb_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed bench for bus_arbiter_2to1: a cycle vector table for arbitration plus
// hand sequences for waiting, reset and the ARB_TIMEOUT_EN watchdog.
module tb_bus_arbiter_2to1;
  import bus_if_types_pkg::*;

  logic        clk, rst_n;
  logic        m0_breq, m0_bstart, m1_breq, m1_bstart;
  ttype_e      m0_ttype, m1_ttype;
  tsize_e      m0_tsize, m1_tsize;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        s_bdone;
  logic [31:0] s_rdata;

  logic        m0_bdone, m1_bdone, s_breq, s_bstart, arb_timeout;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  ttype_e      s_ttype;
  tsize_e      s_tsize;

  logic        fp_m0_bdone, fp_m1_bdone, fp_s_breq, fp_s_bstart, fp_arb_timeout;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  ttype_e      fp_s_ttype;
  tsize_e      fp_s_tsize;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter_2to1 #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_breq(m0_breq), .m0_bstart(m0_bstart), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_bdone(m0_bdone), .m0_rdata(m0_rdata),
    .m1_breq(m1_breq), .m1_bstart(m1_bstart), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bdone(m1_bdone), .m1_rdata(m1_rdata),
    .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_bdone(s_bdone), .s_rdata(s_rdata),
    .arb_timeout(arb_timeout)
  );

  bus_arbiter_2to1 #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_breq(m0_breq), .m0_bstart(m0_bstart), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_bdone(fp_m0_bdone), .m0_rdata(fp_m0_rdata),
    .m1_breq(m1_breq), .m1_bstart(m1_bstart), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bdone(fp_m1_bdone), .m1_rdata(fp_m1_rdata),
    .s_breq(fp_s_breq), .s_bstart(fp_s_bstart), .s_ttype(fp_s_ttype), .s_tsize(fp_s_tsize),
    .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_bdone(s_bdone), .s_rdata(s_rdata),
    .arb_timeout(fp_arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0s, m1s, sd;
    logic [31:0] rd;
    logic        e_sbst;
    logic [31:0] e_addr;
    logic        e_m0d, e_m1d;
    logic [31:0] e_fpaddr;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_breq = 1'b0; m1_breq = 1'b0; m0_bstart = 1'b0; m1_bstart = 1'b0;
    m0_ttype = READ;  m0_tsize = WORD; m0_addr = 32'h100;  m0_wdata = 32'h5555;
    m1_ttype = WRITE; m1_tsize = HALF; m1_addr = 32'h2002; m1_wdata = 32'hABCD;
    s_bdone = 1'b0; s_rdata = '0;

    // Conflict + round-robin vs fixed priority, single m0 (3-cycle slave), stray bdone, single m1.
    //          m0s   m1s   sd    rdata         sbst  addr          m0d   m1d   fp addr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h100,  1'b0, 1'b0, 32'h100};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h1111,    1'b1, 32'h100,  1'b1, 1'b0, 32'h100};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h2002, 1'b0, 1'b0, 32'h100};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h2222,    1'b1, 32'h2002, 1'b0, 1'b1, 32'h100};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,  1'b0, 1'b0, 32'h100};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,  1'b0, 1'b0, 32'h100};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h1234,    1'b1, 32'h100,  1'b1, 1'b0, 32'h100};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hBAD0BAD, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h2002, 1'b0, 1'b0, 32'h2002};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h77,      1'b1, 32'h2002, 1'b0, 1'b1, 32'h2002};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,    1'b0, 1'b0, 32'h0};

    #2;
    chk("rst_s_bstart", 32'(s_bstart), 32'd0);
    chk("rst_s_breq", 32'(s_breq), 32'd0);
    chk("rst_s_ttype", 32'(s_ttype), 32'(READ));
    chk("rst_s_tsize", 32'(s_tsize), 32'(WORD));
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_bdone", {30'd0, m1_bdone, m0_bdone}, 32'd0);
    chk("rst_arb_timeout", 32'(arb_timeout), 32'd0);
    #10 rst_n = 1'b1;
    m0_breq = 1'b1; m1_breq = 1'b1;
    step();

    for (int i = 0; i < 18; i++) begin
      m0_bstart = vecs[i].m0s; m1_bstart = vecs[i].m1s;
      s_bdone = vecs[i].sd; s_rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_s_bstart", i), 32'(s_bstart), 32'(vecs[i].e_sbst));
      chk($sformatf("v%0d_s_addr", i), s_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_m0_bdone", i), 32'(m0_bdone), 32'(vecs[i].e_m0d));
      chk($sformatf("v%0d_m1_bdone", i), 32'(m1_bdone), 32'(vecs[i].e_m1d));
      chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].rd);
      chk($sformatf("v%0d_fp_s_addr", i), fp_s_addr, vecs[i].e_fpaddr);
      step();
    end

    // m1 WRITE HALF waits while m0 owns, then gets the bus after the bubble.
    m0_bstart = 1'b1; #1;
    chk("t3_idle_bstart", 32'(s_bstart), 32'd0);
    step();
    m1_bstart = 1'b1; #1;
    chk("t3_own0_addr", s_addr, 32'h100);
    chk("t3_own0_ttype", 32'(s_ttype), 32'(READ));
    chk("t3_own0_tsize", 32'(s_tsize), 32'(WORD));
    chk("t3_own0_wdata", s_wdata, 32'h5555);
    chk("t3_own0_breq", 32'(s_breq), 32'd1);
    step();
    s_bdone = 1'b1; s_rdata = 32'h4242; #1;
    chk("t3_m0_bdone", 32'(m0_bdone), 32'd1);
    chk("t3_m1_bdone", 32'(m1_bdone), 32'd0);
    chk("t3_still_read", 32'(s_ttype), 32'(READ));
    step();
    s_bdone = 1'b0; s_rdata = '0; m0_bstart = 1'b0; #1;
    chk("t3_bubble_bstart", 32'(s_bstart), 32'd0);
    chk("t3_bubble_ttype", 32'(s_ttype), 32'(READ));
    chk("t3_bubble_wdata", s_wdata, 32'h0);
    chk("t3_bubble_breq", 32'(s_breq), 32'd0);
    step();
    chk("t3_own1_bstart", 32'(s_bstart), 32'd1);
    chk("t3_own1_ttype", 32'(s_ttype), 32'(WRITE));
    chk("t3_own1_tsize", 32'(s_tsize), 32'(HALF));
    chk("t3_own1_wdata", s_wdata, 32'hABCD);
    chk("t3_own1_addr", s_addr, 32'h2002);
    m1_bstart = 1'b0; #1;
    chk("t3_drop_bstart", 32'(s_bstart), 32'd0);
    chk("t3_drop_addr", s_addr, 32'h2002);
    step();
    chk("t3_kept_addr", s_addr, 32'h2002);
    s_bdone = 1'b1; s_rdata = 32'h9999; #1;
    chk("t3_m1_bdone_late", 32'(m1_bdone), 32'd1);
    chk("t3_m1_rdata", m1_rdata, 32'h9999);
    step();
    s_bdone = 1'b0; s_rdata = '0;

    // Serve m0 (round-robin now favours m1), then reset in the middle of OWN1.
    m0_bstart = 1'b1; step();
    s_bdone = 1'b1; step();
    s_bdone = 1'b0; m0_bstart = 1'b0;
    m1_bstart = 1'b1; step();
    chk("t5_own1_bstart", 32'(s_bstart), 32'd1);
    chk("t5_own1_addr", s_addr, 32'h2002);
    #2 rst_n = 1'b0;
    s_bdone = 1'b1; #1;
    chk("t5_rst_bstart", 32'(s_bstart), 32'd0);
    chk("t5_rst_breq", 32'(s_breq), 32'd0);
    chk("t5_rst_addr", s_addr, 32'h0);
    chk("t5_rst_wdata", s_wdata, 32'h0);
    chk("t5_rst_ttype", 32'(s_ttype), 32'(READ));
    chk("t5_rst_bdone", {30'd0, m1_bdone, m0_bdone}, 32'd0);
    s_bdone = 1'b0; m0_bstart = 1'b1;
    #1 rst_n = 1'b1;
    step();
    chk("t5_post_rst_winner", s_addr, 32'h100);
    s_bdone = 1'b1; #1;
    chk("t5_post_rst_m0_bdone", 32'(m0_bdone), 32'd1);
    step();
    s_bdone = 1'b0; m0_bstart = 1'b0;
    step();
    chk("t5_m1_after", s_addr, 32'h2002);
    s_bdone = 1'b1; step();
    s_bdone = 1'b0; m1_bstart = 1'b0; step();

    // Slave never answers while m0 owns.
    m0_bstart = 1'b1; s_rdata = 32'h600D;
    step();
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("t6_c%0d_m0_bdone", k), 32'(m0_bdone), 32'd0);
      chk($sformatf("t6_c%0d_s_bstart", k), 32'(s_bstart), 32'd1);
      step();
    end
`ifdef ARB_TIMEOUT_EN
    chk("t6_to_m0_bdone", 32'(m0_bdone), 32'd1);
    chk("t6_to_m1_bdone", 32'(m1_bdone), 32'd0);
    chk("t6_to_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t6_to_s_bstart", 32'(s_bstart), 32'd0);
    step();
    m0_bstart = 1'b0; #1;
    chk("t6_to_idle", 32'(s_bstart), 32'd0);
    chk("t6_to_flag", 32'(arb_timeout), 32'd1);
    step(); step(); step();
    chk("t6_to_sticky", 32'(arb_timeout), 32'd1);
`else
    chk("t6_c8_m0_bdone", 32'(m0_bdone), 32'd0);
    chk("t6_c8_rdata", m0_rdata, 32'h600D);
    step(); step(); step(); step();
    chk("t6_held_bstart", 32'(s_bstart), 32'd1);
    chk("t6_held_addr", s_addr, 32'h100);
    chk("t6_no_flag", 32'(arb_timeout), 32'd0);
    s_bdone = 1'b1; #1;
    chk("t6_late_bdone", 32'(m0_bdone), 32'd1);
    step();
    s_bdone = 1'b0; m0_bstart = 1'b0;
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
